// File: rtl/div_pkg.sv
// Shared constants and types for the iterative 32-bit divider.
package div_pkg;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam logic [DIV_W-1:0] DIV_DZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] i_pr,
    input  logic             i_bit,
    input  logic [DIV_W-1:0] i_d,
    output logic [DIV_W-1:0] o_pr,
    output logic             o_qbit
);

    logic [DIV_W:0] w_shift;
    logic [DIV_W:0] w_diff;

    assign w_shift = {i_pr, i_bit};
    assign w_diff  = w_shift - {1'b0, i_d};

    // A non-negative trial difference always fits back into DIV_W bits.
    always_comb begin
        o_qbit = ~w_diff[DIV_W];
        o_pr   = w_diff[DIV_W] ? w_shift[DIV_W-1:0] : w_diff[DIV_W-1:0];
    end

endmodule

// File: rtl/div32.sv
// Multi-cycle signed/unsigned 32-bit divider: fixed 33-cycle latency, done pulse.
module div32
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [DIV_W-1:0] ain,
    input  logic [DIV_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quot,
    output logic [DIV_W-1:0] rem
);

    div_state_t       r_state;
    logic [4:0]       r_cnt;
    logic [DIV_W-1:0] r_pr;
    logic [DIV_W-1:0] r_q;
    logic [DIV_W-1:0] r_d;
    logic [DIV_W-1:0] r_ain;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [DIV_W-1:0] r_quot;
    logic [DIV_W-1:0] r_rem;

    logic [DIV_W-1:0] w_a_mag;
    logic [DIV_W-1:0] w_b_mag;
    logic [DIV_W-1:0] w_pr_next;
    logic             w_qbit;

    assign w_a_mag = (sgn && ain[DIV_W-1]) ? (~ain + 1'b1) : ain;
    assign w_b_mag = (sgn && bin[DIV_W-1]) ? (~bin + 1'b1) : bin;

    // The dividend register doubles as the quotient shift register.
    div_step u_step (
        .i_pr   (r_pr),
        .i_bit  (r_q[DIV_W-1]),
        .i_d    (r_d),
        .o_pr   (w_pr_next),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pr    <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_ain   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_q     <= w_a_mag;
                        r_d     <= w_b_mag;
                        r_ain   <= ain;
                        r_neg_q <= sgn & (ain[DIV_W-1] ^ bin[DIV_W-1]);
                        r_neg_r <= sgn & ain[DIV_W-1];
                        r_dz    <= (bin == '0);
                        r_pr    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_pr  <= w_pr_next;
                    r_q   <= {r_q[DIV_W-2:0], w_qbit};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_dz) begin
                        r_quot <= DIV_DZ_QUOT;
                        r_rem  <= r_ain;
                    end else begin
                        r_quot <= r_neg_q ? (~r_q + 1'b1) : r_q;
                        r_rem  <= r_neg_r ? (~r_pr + 1'b1) : r_pr;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quot = r_quot;
    assign rem  = r_rem;

endmodule

// File: tb/tb_div32.sv
// Directed vector bench for div32: results, latency, handshake and reset abort.
module tb_div32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] ain;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;

    int checks;
    int errors;

    div32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .ain   (ain),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .quot  (quot),
        .rem   (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    vec_t vecs [12];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller must be at a negedge; returns at the negedge where done is seen.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        sgn   = s;
        ain   = a;
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check32("busy_after_start", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check32(name, seen, 0);
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sgn    = 1'b0;
        ain    = '0;
        bin    = '0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[10] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
        vecs[11] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};

        repeat (3) @(negedge clk);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_done", {31'd0, done}, 32'd0);
        check32("reset_quot", quot, 32'd0);
        check32("reset_rem",  rem,  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Each launch is issued in the previous done cycle: back-to-back throughput.
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].s, vecs[i].a, vecs[i].b, lat);
            check32($sformatf("latency[%0d]", i), lat, 33);
            check32($sformatf("quot[%0d]", i), quot, vecs[i].eq);
            check32($sformatf("rem[%0d]", i),  rem,  vecs[i].er);
            check32($sformatf("idle_at_done[%0d]", i), {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        check32("done_one_cycle", {31'd0, done}, 32'd0);

        // Second start mid-operation must be ignored.
        sgn = 1'b0; ain = 32'd100; bin = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (9) begin @(negedge clk); lat++; end
        sgn = 1'b0; ain = 32'd9; bin = 32'd3; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check32("ignored_start_latency", lat, 33);
        check32("ignored_start_quot", quot, 32'd14);
        check32("ignored_start_rem",  rem,  32'd2);
        expect_no_done("ignored_start_no_second_done", 40);

        // Reset mid-operation aborts with no done.
        launch_abort();
        expect_no_done("abort_no_done", 40);
        check32("abort_quot_held", quot, 32'd0);
        launch(1'b0, 32'd9, 32'd3, lat);
        check32("post_reset_latency", lat, 33);
        check32("post_reset_quot", quot, 32'd3);
        check32("post_reset_rem",  rem,  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic launch_abort();
        sgn = 1'b1; ain = 32'd7; bin = 32'hFFFF_FFFE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_done", {31'd0, done}, 32'd0);
        check32("abort_quot", quot, 32'd0);
        check32("abort_rem",  rem,  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

endmodule
